// File: rtl/controlador_determinante_5x5_pkg.sv
// Shared sizing, types and state encoding for the 5x5 Bareiss determinant blocks.
// The element helper keeps the packed-input layout in one place.
package controlador_determinante_5x5_pkg;

    localparam int N      = 5;
    localparam int ELEM_W = 8;
    localparam int ACC_W  = 48;
    localparam int PROD_W = 96;
    localparam int IDX_W  = 3;
    localparam int MAT_W  = N * N * ELEM_W;

    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic [IDX_W-1:0]         idx_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PIVOT  = 2'd1,
        ELIM   = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam idx_t LAST_IDX = idx_t'(N - 1);
    localparam idx_t LAST_K   = idx_t'(N - 2);

    // Bit offset of element [i][j] inside the packed 200-bit input.
    function automatic int elem_lsb(input int i, input int j);
        return (i * N + j) * ELEM_W;
    endfunction

endpackage

// File: rtl/controlador_determinante_5x5_bareiss_pe.sv
// One fraction-free Bareiss update: (a_kk*a_ij - a_ik*a_kj) / prev.
// Products are formed at full width so the exact quotient always fits in ACC_W.
module bareiss_pe
    import controlador_determinante_5x5_pkg::*;
(
    input  logic signed [ACC_W-1:0] a_kk_i,
    input  logic signed [ACC_W-1:0] a_ij_i,
    input  logic signed [ACC_W-1:0] a_ik_i,
    input  logic signed [ACC_W-1:0] a_kj_i,
    input  logic signed [ACC_W-1:0] prev_i,
    output logic signed [ACC_W-1:0] q_o
);

    prod_t kk_x, ij_x, ik_x, kj_x, prev_x;
    prod_t num;

    assign kk_x   = a_kk_i;
    assign ij_x   = a_ij_i;
    assign ik_x   = a_ik_i;
    assign kj_x   = a_kj_i;
    assign prev_x = prev_i;

    assign num = (kk_x * ij_x) - (ik_x * kj_x);
    // Division is exact by construction; truncation to ACC_W loses nothing.
    assign q_o = acc_t'(num / prev_x);

endmodule

// File: rtl/controlador_determinante_5x5.sv
// Multi-cycle exact 5x5 determinant: in-place Bareiss elimination with row pivoting,
// one element update per cycle through a single shared bareiss_pe.
module controlador_determinante_5x5
    import controlador_determinante_5x5_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [MAT_W-1:0] matriz_5x5,
    output logic                    busy,
    output logic                    done,
    output logic signed [ACC_W-1:0] det,
    output logic                    singular
);

    state_t state_q, state_d;

    acc_t m_q [N][N];
    acc_t elem_in [N][N];
    idx_t k_q, i_q, j_q;
    acc_t prev_q;
    logic sign_q;
    acc_t det_q;
    logic singular_q;
    logic done_q;

    logic piv_found;
    idx_t piv_row;
    logic last_elem;
    acc_t pe_q;

    // Sign-extend every packed 8-bit element to the accumulator width.
    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            localparam int LSB = elem_lsb(gi, gj);
            assign elem_in[gi][gj] = {{(ACC_W-ELEM_W){matriz_5x5[LSB+ELEM_W-1]}},
                                      matriz_5x5[LSB +: ELEM_W]};
        end
    end

    // Lowest row at or below k with a nonzero entry in column k.
    always_comb begin
        piv_found = 1'b0;
        piv_row   = k_q;
        for (int r = N - 1; r >= 0; r--) begin
            if (r >= int'(k_q) && m_q[r][k_q] != '0) begin
                piv_found = 1'b1;
                piv_row   = idx_t'(r);
            end
        end
    end

    assign last_elem = (i_q == LAST_IDX) && (j_q == LAST_IDX);

    bareiss_pe u_pe (
        .a_kk_i (m_q[k_q][k_q]),
        .a_ij_i (m_q[i_q][j_q]),
        .a_ik_i (m_q[i_q][k_q]),
        .a_kj_i (m_q[k_q][j_q]),
        .prev_i (prev_q),
        .q_o    (pe_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PIVOT;
                end
            end
            PIVOT: begin
                state_d = piv_found ? ELIM : IDLE;
            end
            ELIM: begin
                if (last_elem) begin
                    state_d = (k_q == LAST_K) ? FINISH : PIVOT;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    m_q[r][c] <= '0;
                end
            end
            k_q        <= '0;
            i_q        <= '0;
            j_q        <= '0;
            prev_q     <= acc_t'(1);
            sign_q     <= 1'b0;
            det_q      <= '0;
            singular_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        for (int r = 0; r < N; r++) begin
                            for (int c = 0; c < N; c++) begin
                                m_q[r][c] <= elem_in[r][c];
                            end
                        end
                        k_q    <= '0;
                        prev_q <= acc_t'(1);
                        sign_q <= 1'b0;
                    end
                end
                PIVOT: begin
                    if (piv_found) begin
                        if (piv_row != k_q) begin
                            for (int c = 0; c < N; c++) begin
                                m_q[k_q][c]     <= m_q[piv_row][c];
                                m_q[piv_row][c] <= m_q[k_q][c];
                            end
                            sign_q <= ~sign_q;
                        end
                        i_q <= k_q + idx_t'(1);
                        j_q <= k_q + idx_t'(1);
                    end else begin
                        det_q      <= '0;
                        singular_q <= 1'b1;
                        done_q     <= 1'b1;
                    end
                end
                ELIM: begin
                    m_q[i_q][j_q] <= pe_q;
                    if (j_q == LAST_IDX) begin
                        j_q <= k_q + idx_t'(1);
                        i_q <= i_q + idx_t'(1);
                    end else begin
                        j_q <= j_q + idx_t'(1);
                    end
                    // The pivot of this step becomes the divisor of the next one.
                    if (last_elem) begin
                        prev_q <= m_q[k_q][k_q];
                        k_q    <= k_q + idx_t'(1);
                    end
                end
                FINISH: begin
                    det_q      <= sign_q ? -m_q[N-1][N-1] : m_q[N-1][N-1];
                    singular_q <= (m_q[N-1][N-1] == '0);
                    done_q     <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign det      = det_q;
    assign singular = singular_q;

endmodule

// File: tb/tb_controlador_determinante_5x5.sv
// Directed bench for the 5x5 determinant controller: hand-computed determinants,
// latencies, start-ignore, back-to-back start and mid-run reset.
module tb_controlador_determinante_5x5;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [199:0]       matriz;
    logic               busy;
    logic               done;
    logic signed [47:0] det;
    logic               singular;

    int total = 0;
    int bad   = 0;

    logic signed [7:0] mat [5][5];

    controlador_determinante_5x5 dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .matriz_5x5 (matriz),
        .busy       (busy),
        .done       (done),
        .det        (det),
        .singular   (singular)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [199:0] pack_mat();
        logic [199:0] p;
        p = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                p[(i*40 + j*8) +: 8] = mat[i][j];
        return p;
    endfunction

    task automatic set_diag(input logic signed [7:0] v);
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                mat[i][j] = (i == j) ? v : 8'sd0;
    endtask

    // Drive start for one edge; returns #1 after the accepting edge.
    task automatic launch();
        matriz = pack_mat();
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    task automatic wait_done(input int n0, output int lat, output bit busy_ok);
        lat     = n0;
        busy_ok = 1'b1;
        while (lat < 200) begin
            step();
            lat++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic run_check(input string tag, input logic [47:0] exp_det,
                             input logic exp_sing, input int exp_lat);
        int lat;
        bit bok;
        launch();
        wait_done(0, lat, bok);
        check({tag, "_latency"}, 48'(lat), 48'(exp_lat));
        check({tag, "_busy_during"}, 48'(bok), 48'(1));
        check({tag, "_det"}, det, exp_det);
        check({tag, "_singular"}, 48'(singular), 48'(exp_sing));
        check({tag, "_busy_at_done"}, 48'(busy), 48'(0));
        step();
        check({tag, "_done_pulse"}, 48'(done), 48'(0));
        check({tag, "_det_held"}, det, exp_det);
    endtask

    initial begin
        int lat;
        int extra;
        bit bok;

        rst    = 1'b1;
        start  = 1'b0;
        matriz = '0;
        repeat (3) step();
        check("rst_busy", 48'(busy), 48'(0));
        check("rst_done", 48'(done), 48'(0));
        check("rst_det", det, 48'(0));
        check("rst_singular", 48'(singular), 48'(0));
        rst = 1'b0;
        step();

        set_diag(8'sd1);
        run_check("identity", 48'(1), 1'b0, 35);

        set_diag(8'sd127);
        run_check("diag127", 48'(64'sd33038369407), 1'b0, 35);

        set_diag(-8'sd128);
        run_check("diag_m128", 48'(-64'sd34359738368), 1'b0, 35);

        set_diag(8'sd1);
        mat[0][0] = 8'sd0; mat[0][1] = 8'sd1;
        mat[1][0] = 8'sd1; mat[1][1] = 8'sd0;
        run_check("swap01", 48'(-1), 1'b0, 35);

        set_diag(8'sd0);
        run_check("zero", 48'(0), 1'b1, 1);

        set_diag(8'sd1);
        mat[4][4] = 8'sd0; mat[4][3] = 8'sd1;
        run_check("row4_eq_row3", 48'(0), 1'b1, 35);

        set_diag(8'sd1);
        mat[1][1] = 8'sd0;
        run_check("col1_zero", 48'(0), 1'b1, 18);

        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                mat[i][j] = (i == j) ? 8'sd2 : (((i - j) == 1 || (j - i) == 1) ? 8'sd1 : 8'sd0);
        run_check("tridiag", 48'(6), 1'b0, 35);

        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                mat[i][j] = (i + j == 4) ? 8'sd1 : 8'sd0;
        run_check("anti_identity", 48'(1), 1'b0, 35);

        // Second start mid-run must be ignored.
        set_diag(8'sd2);
        launch();
        repeat (9) step();
        set_diag(8'sd0);
        matriz = pack_mat();
        start  = 1'b1;
        step();
        start  = 1'b0;
        wait_done(10, lat, bok);
        check("ignore_latency", 48'(lat), 48'(35));
        check("ignore_busy_during", 48'(bok), 48'(1));
        check("ignore_det", det, 48'(32));
        extra = 0;
        repeat (40) begin
            step();
            if (done) extra++;
        end
        check("ignore_extra_done", 48'(extra), 48'(0));
        check("ignore_idle_after", 48'(busy), 48'(0));

        // Start accepted in the done cycle; det holds until the next done.
        set_diag(8'sd1);
        launch();
        wait_done(0, lat, bok);
        check("b2b_first_det", det, 48'(1));
        set_diag(8'sd127);
        matriz = pack_mat();
        start  = 1'b1;
        step();
        start  = 1'b0;
        check("b2b_busy", 48'(busy), 48'(1));
        check("b2b_det_held", det, 48'(1));
        check("b2b_done_low", 48'(done), 48'(0));
        wait_done(0, lat, bok);
        check("b2b_latency", 48'(lat), 48'(35));
        check("b2b_det", det, 48'(64'sd33038369407));

        // Reset in the middle of a run aborts it with no done.
        step();
        set_diag(-8'sd128);
        launch();
        repeat (19) step();
        rst = 1'b1;
        step();
        check("abort_busy", 48'(busy), 48'(0));
        check("abort_done", 48'(done), 48'(0));
        check("abort_det", det, 48'(0));
        check("abort_singular", 48'(singular), 48'(0));
        rst = 1'b0;
        extra = 0;
        repeat (40) begin
            step();
            if (done || busy) extra++;
        end
        check("abort_no_activity", 48'(extra), 48'(0));

        set_diag(8'sd1);
        mat[0][0] = 8'sd0; mat[0][1] = 8'sd1;
        mat[1][0] = 8'sd1; mat[1][1] = 8'sd0;
        run_check("after_abort", 48'(-1), 1'b0, 35);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
